// File: rtl/rf_pkg.sv
// Shared register-file constants and the dump engine state encoding.
package rf_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks addresses 0..NUM_REGS-1 through a spare
// read port, streams {addr, data} over valid/ready, and flags coherency
// loss when a snooped write hits a register that is already captured.
module regfile_dump #(
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              dirty
);

    import rf_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic              snoop_hit;

    assign idx_nxt   = idx + ADDR_W'(1);
    // A write at or below idx hits a register whose value is (or is being)
    // captured: at idx in FETCH the old value is sampled on the same edge.
    assign snoop_hit = (state != IDLE) && snoop_we && (snoop_addr <= idx);

    // Dump sequencer with registered outputs; done pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            rf_addr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dirty     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        rf_addr <= '0;
                        dirty   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    out_data  <= rf_data;
                    out_addr  <= idx;
                    out_last  <= (idx == LAST_ADDR);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            rf_addr <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            idx     <= idx_nxt;
                            rf_addr <= idx_nxt;
                            state   <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Sticky until the next accepted start (which only clears in IDLE).
            if (snoop_hit) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file feeds the read port;
// a snapshot model predicts each streamed word and the dirty flag.
module tb_regfile_dump;

    localparam int NR = 32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        snoop_we;
    logic [4:0]  snoop_addr;
    logic [31:0] wdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        dirty;

    logic [31:0] regs   [NR];
    logic [31:0] shadow [NR];
    int          checks;
    int          errors;
    logic        last_dirty;

    regfile_dump dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .snoop_we   (snoop_we),
        .snoop_addr (snoop_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .dirty      (dirty)
    );

    always #5 clk = ~clk;

    // Behavioural register file: write on posedge, combinational read.
    always @(posedge clk) begin
        if (snoop_we) regs[snoop_addr] <= wdata;
    end
    assign rf_data = regs[rf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load every register through the write port while idle.
    task automatic preload(input bit rnd);
        for (int i = 0; i < NR; i++) begin
            snoop_we   = 1'b1;
            snoop_addr = 5'(i);
            wdata      = rnd ? $urandom : (32'(i) * 32'h01010101);
            shadow[i]  = wdata;
            @(negedge clk);
        end
        snoop_we = 1'b0;
        chk("dirty_sticky_idle", {31'd0, dirty}, {31'd0, last_dirty});
    endtask

    // One dump from start to done, with an optional snooped write, a
    // spurious start, or a mid-dump reset keyed to the number of words
    // already accepted by the sink.
    task automatic run_dump(input bit rnd_ready, input int w_cnt, input logic [4:0] w_addr,
                            input logic [31:0] w_data, input bit w_send,
                            input int spur_at, input int rst_at);
        logic [31:0] expd [NR];
        int          count;
        int          cyc;
        bit          exp_dirty;
        bit          fin;
        bit          wdone;
        bit          sdone;
        logic        pv;
        logic        pr;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        pl;
        for (int i = 0; i < NR; i++) expd[i] = shadow[i];
        count = 0; exp_dirty = 0; fin = 0; wdone = 0; sdone = 0;
        pv = 0; pr = 0; pa = '0; pd = '0; pl = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!fin && cyc < 400) begin
            snoop_we = 1'b0;
            chk("busy_in_dump", {31'd0, busy}, 32'd1);
            chk("done_low_in_dump", {31'd0, done}, 32'd0);
            if (cyc == 1) chk("fetch_first_not_valid", {31'd0, out_valid}, 32'd0);
            if (pv && !pr) begin
                chk("stall_addr_stable", {27'd0, out_addr}, {27'd0, pa});
                chk("stall_data_stable", out_data, pd);
                chk("stall_last_stable", {31'd0, out_last}, {31'd0, pl});
                chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            end
            if (out_valid) begin
                chk("word_addr", {27'd0, out_addr}, 32'(count));
                chk("word_data", out_data, expd[count]);
                chk("word_last", {31'd0, out_last}, {31'd0, (count == NR - 1)});
            end
            if (rst_at >= 0 && count == rst_at && !out_valid) begin
                rst_n = 1'b0;
                #1;
                chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                chk("rst_mid_dirty", {31'd0, dirty}, 32'd0);
                chk("rst_mid_addr", {27'd0, out_addr}, 32'd0);
                @(negedge clk);
                chk("rst_mid_no_done", {31'd0, done}, 32'd0);
                rst_n = 1'b1;
                last_dirty = 1'b0;
                @(negedge clk);
                chk("rst_after_no_done", {31'd0, done}, 32'd0);
                chk("rst_after_idle", {31'd0, busy}, 32'd0);
                return;
            end
            out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
            start = (spur_at >= 0 && count == spur_at && out_valid && !sdone);
            if (start) sdone = 1;
            if (!wdone && w_cnt >= 0 && count == w_cnt && (out_valid == w_send)) begin
                snoop_we   = 1'b1;
                snoop_addr = w_addr;
                wdata      = w_data;
                shadow[w_addr] = w_data;
                if (int'(w_addr) <= count) exp_dirty = 1;
                else expd[w_addr] = w_data;
                wdone = 1;
            end
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data; pl = out_last;
            if (out_valid && out_ready) begin
                if (count == NR - 1) fin = 1;
                count++;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        snoop_we = 1'b0;
        chk("dump_completed", {31'd0, fin}, 32'd1);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy_low", {31'd0, busy}, 32'd0);
        chk("done_valid_low", {31'd0, out_valid}, 32'd0);
        chk("dirty_end", {31'd0, dirty}, {31'd0, exp_dirty});
        chk("word_count", 32'(count), 32'(NR));
        if (!rnd_ready) chk("done_cycle", 32'(cyc), 32'd65);
        last_dirty = exp_dirty;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("dirty_held", {31'd0, dirty}, {31'd0, exp_dirty});
    endtask

    initial begin
        int k;
        clk = 0; rst_n = 0; start = 0; snoop_we = 0; snoop_addr = '0;
        wdata = '0; out_ready = 0; checks = 0; errors = 0; last_dirty = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dirty", {31'd0, dirty}, 32'd0);
        chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
        chk("rst_out_addr", {27'd0, out_addr}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Clean dump of a patterned file with the sink always ready.
        preload(0);
        run_dump(0, -1, '0, '0, 0, -1, -1);
        // Same contents, random backpressure.
        run_dump(1, -1, '0, '0, 0, -1, -1);
        // Write behind the cursor: dirty, old value streamed.
        preload(1);
        run_dump(1, 10, 5'd3, 32'hDEADBEEF, 1, -1, -1);
        // Idle writes must not clear the sticky flag.
        preload(1);
        // Write ahead of the cursor: clean, new value streamed.
        run_dump(1, 10, 5'd20, 32'hCAFEF00D, 1, -1, -1);
        // Write to the register being fetched: old value, dirty.
        run_dump(1, 7, 5'd7, 32'h12345678, 0, -1, -1);
        // Same-address write in SEND and on the last register.
        run_dump(0, 31, 5'd31, 32'h0BADF00D, 1, -1, -1);
        // Write to address 0 just as word 0 is fetched.
        run_dump(0, 0, 5'd0, 32'h55AA55AA, 0, -1, -1);
        // Random write position and target.
        for (int t = 0; t < 3; t++) begin
            k = int'($urandom_range(0, NR - 1));
            run_dump(1, k, 5'($urandom_range(0, NR - 1)), $urandom, 1'($urandom % 2), -1, -1);
        end
        // Spurious start mid-dump is ignored.
        run_dump(1, -1, '0, '0, 0, 5, -1);
        // Reset mid-dump, then a fresh full dump.
        run_dump(0, -1, '0, '0, 0, -1, 12);
        preload(0);
        run_dump(0, -1, '0, '0, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
